// File: rtl/multi_cycle_control_unit_if.sv
// multi_cycle_control_unit_if: control-unit <-> datapath/memory signal bundle.
// master = control unit (drives selects/enables), slave = datapath + memory.
interface multi_cycle_control_unit_if;

  // Datapath status into the control unit
  logic [6:0] opcode;
  logic       bcond;
  logic       mem_ready;

  // Memory handshake
  logic       mem_req;
  logic       mem_write;
  logic       i_or_d;

  // Datapath selects and enables
  logic       ir_write;
  logic       reg_write;
  logic [1:0] mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       pc_write;
  logic [1:0] pc_source;

  modport master (
    input  opcode, bcond, mem_ready,
    output mem_req, mem_write, i_or_d, ir_write, reg_write, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, pc_write, pc_source
  );

  modport slave (
    output opcode, bcond, mem_ready,
    input  mem_req, mem_write, i_or_d, ir_write, reg_write, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, pc_write, pc_source
  );

endinterface

// File: rtl/multi_cycle_control_unit.sv
// multi_cycle_control_unit: Moore FSM sequencing an RV32I multi-cycle datapath
// over a shared instruction/data memory, plus a retired-instruction counter.
// Optional feature macro: ECALL_HALT_EN (ECALL parks the core in HALT);
// when undefined ECALL retires as a NOP and is_halted is tied low.
module multi_cycle_control_unit #(
  parameter int unsigned CNT_W = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  multi_cycle_control_unit_if.master bus,
  output logic                      illegal_inst,
  output logic                      is_halted,
  output logic [CNT_W-1:0]          instret,
  output logic [2:0]                state
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  // RV32I major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  // ALU operation encodings
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_BR  = 2'd1;
  localparam logic [1:0] ALU_R   = 2'd2;
  localparam logic [1:0] ALU_I   = 2'd3;

  // ALU B operand select
  localparam logic [1:0] SRCB_RS2 = 2'd0;
  localparam logic [1:0] SRCB_IMM = 2'd2;

  // Register-file write-data select
  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MDR = 2'd1;
  localparam logic [1:0] M2R_PC4 = 2'd2;

  // Next-PC select
  localparam logic [1:0] PCSRC_SEQ  = 2'd0;
  localparam logic [1:0] PCSRC_ALU  = 2'd1;
  localparam logic [1:0] PCSRC_JALR = 2'd2;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  instret_q;

  // Opcode class decode; IR is stable from ID through the end of the instruction
  logic is_r;
  logic is_i;
  logic is_load;
  logic is_store;
  logic is_branch;
  logic is_jal;
  logic is_jalr;
  logic is_ecall;
  logic is_legal;

  assign is_r      = (bus.opcode == OP_R);
  assign is_i      = (bus.opcode == OP_I);
  assign is_load   = (bus.opcode == OP_LOAD);
  assign is_store  = (bus.opcode == OP_STORE);
  assign is_branch = (bus.opcode == OP_BRANCH);
  assign is_jal    = (bus.opcode == OP_JAL);
  assign is_jalr   = (bus.opcode == OP_JALR);
  assign is_ecall  = (bus.opcode == OP_ECALL);
  assign is_legal  = is_r | is_i | is_load | is_store | is_branch | is_jal | is_jalr;

  // Ungated decode of the current state; gated by reset at the ports
  logic       mem_req_c;
  logic       mem_write_c;
  logic       i_or_d_c;
  logic       ir_write_c;
  logic       reg_write_c;
  logic [1:0] mem_to_reg_c;
  logic       alu_src_a_c;
  logic [1:0] alu_src_b_c;
  logic [1:0] alu_op_c;
  logic       pc_write_c;
  logic [1:0] pc_source_c;
  logic       illegal_c;
  logic       retire_c;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: begin
        if (bus.mem_ready) begin
          state_d = S_ID;
        end
      end
      S_ID: begin
        if (is_ecall) begin
`ifdef ECALL_HALT_EN
          state_d = S_HALT;
`else
          state_d = S_IF;
`endif
        end else if (is_legal) begin
          state_d = S_EX;
        end else begin
          state_d = S_IF;
        end
      end
      S_EX: begin
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_r || is_i || is_jal || is_jalr) begin
          state_d = S_WB;
        end else begin
          state_d = S_IF;
        end
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          state_d = is_load ? S_WB : S_IF;
        end
      end
      S_WB:    state_d = S_IF;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // Output decode per state (Moore, except ir_write/store retire on mem_ready and pc_source on bcond)
  always_comb begin
    mem_req_c    = 1'b0;
    mem_write_c  = 1'b0;
    i_or_d_c     = 1'b0;
    ir_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    mem_to_reg_c = M2R_ALU;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = SRCB_RS2;
    alu_op_c     = ALU_ADD;
    pc_write_c   = 1'b0;
    pc_source_c  = PCSRC_SEQ;
    illegal_c    = 1'b0;
    retire_c     = 1'b0;
    case (state_q)
      S_IF: begin
        mem_req_c  = 1'b1;
        i_or_d_c   = 1'b0;
        ir_write_c = bus.mem_ready;
      end
      S_ID: begin
        // ALUOut <= PC + imm: speculative branch/JAL target
        alu_src_a_c = 1'b0;
        alu_src_b_c = SRCB_IMM;
        alu_op_c    = ALU_ADD;
        if (is_ecall) begin
          retire_c = 1'b1;
`ifndef ECALL_HALT_EN
          pc_write_c  = 1'b1;
          pc_source_c = PCSRC_SEQ;
`endif
        end else if (!is_legal) begin
          illegal_c   = 1'b1;
          pc_write_c  = 1'b1;
          pc_source_c = PCSRC_SEQ;
          retire_c    = 1'b1;
        end
      end
      S_EX: begin
        if (is_r) begin
          alu_src_a_c = 1'b1;
          alu_src_b_c = SRCB_RS2;
          alu_op_c    = ALU_R;
        end else if (is_i) begin
          alu_src_a_c = 1'b1;
          alu_src_b_c = SRCB_IMM;
          alu_op_c    = ALU_I;
        end else if (is_load || is_store) begin
          alu_src_a_c = 1'b1;
          alu_src_b_c = SRCB_IMM;
          alu_op_c    = ALU_ADD;
        end else if (is_branch) begin
          // Compare uses the ALU; the taken target already sits in ALUOut
          alu_src_a_c = 1'b1;
          alu_src_b_c = SRCB_RS2;
          alu_op_c    = ALU_BR;
          pc_write_c  = 1'b1;
          pc_source_c = bus.bcond ? PCSRC_ALU : PCSRC_SEQ;
          retire_c    = 1'b1;
        end else if (is_jalr) begin
          alu_src_a_c = 1'b1;
          alu_src_b_c = SRCB_IMM;
          alu_op_c    = ALU_ADD;
        end
        // JAL leaves ALUOut holding the ID-computed target
      end
      S_MEM: begin
        mem_req_c   = 1'b1;
        i_or_d_c    = 1'b1;
        mem_write_c = is_store;
        if (bus.mem_ready && is_store) begin
          pc_write_c  = 1'b1;
          pc_source_c = PCSRC_SEQ;
          retire_c    = 1'b1;
        end
      end
      S_WB: begin
        reg_write_c = 1'b1;
        pc_write_c  = 1'b1;
        retire_c    = 1'b1;
        if (is_load) begin
          mem_to_reg_c = M2R_MDR;
        end else if (is_jal || is_jalr) begin
          mem_to_reg_c = M2R_PC4;
        end
        if (is_jal) begin
          pc_source_c = PCSRC_ALU;
        end else if (is_jalr) begin
          pc_source_c = PCSRC_JALR;
        end
      end
      default: begin
        // HALT and unused encodings: every enable stays low
      end
    endcase
  end

  // Retired-instruction counter, wraps modulo 2^CNT_W
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret_q <= '0;
    end else if (retire_c) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  // Port drive: everything forced low while reset is asserted, even mid-access
  assign bus.mem_req    = reset & mem_req_c;
  assign bus.mem_write  = reset & mem_write_c;
  assign bus.i_or_d     = reset & i_or_d_c;
  assign bus.ir_write   = reset & ir_write_c;
  assign bus.reg_write  = reset & reg_write_c;
  assign bus.mem_to_reg = reset ? mem_to_reg_c : 2'd0;
  assign bus.alu_src_a  = reset & alu_src_a_c;
  assign bus.alu_src_b  = reset ? alu_src_b_c : 2'd0;
  assign bus.alu_op     = reset ? alu_op_c : 2'd0;
  assign bus.pc_write   = reset & pc_write_c;
  assign bus.pc_source  = reset ? pc_source_c : 2'd0;
  assign illegal_inst   = reset & illegal_c;
  assign instret        = instret_q;
  assign state          = 3'(state_q);

`ifdef ECALL_HALT_EN
  assign is_halted = reset & (state_q == S_HALT);
`else
  assign is_halted = 1'b0;
`endif

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// tb_multi_cycle_control_unit: table-driven instruction runs with a scoreboard
// of expected per-instruction results, plus hand sequences for reset, ECALL
// and counter wrap.
module tb_multi_cycle_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        illegal_inst;
  logic        is_halted;
  logic [31:0] instret;
  logic [2:0]  state;

  logic        illegal4;
  logic        halted4;
  logic [3:0]  instret4;
  logic [2:0]  state4;

  multi_cycle_control_unit_if bus ();
  multi_cycle_control_unit_if bus4 ();

  multi_cycle_control_unit #(.CNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .illegal_inst (illegal_inst),
    .is_halted    (is_halted),
    .instret      (instret),
    .state        (state)
  );

  multi_cycle_control_unit #(.CNT_W(4)) dut_wrap (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus4),
    .illegal_inst (illegal4),
    .is_halted    (halted4),
    .instret      (instret4),
    .state        (state4)
  );

  always #5 clk = ~clk;

  // One instruction: stimulus plus the results it must produce
  typedef struct {
    logic [6:0] opcode;
    logic       bcond;
    int         if_wait;
    int         mem_wait;
    int         lat;
    logic [1:0] pc_src;
    int         reg_wr;
    logic [1:0] m2r;
    int         mem_wr;
    int         illegal;
    int         mreq;
    int         dreq;
  } vec_t;

  // What the DUT actually did over one instruction
  typedef struct {
    int         lat;
    logic [1:0] pc_src;
    int         reg_wr;
    logic [1:0] m2r;
    int         mem_wr;
    int         illegal;
    int         mreq;
    int         dreq;
    int         ir_wr;
  } res_t;

  localparam int NVEC = 13;
  vec_t vecs[NVEC];
  vec_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int exp_instret = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pop the oldest expectation and compare it against the observed instruction
  task automatic compare(input int idx, input res_t a);
    vec_t e;
    e = exp_q.pop_front();
    check($sformatf("v%0d.latency", idx), 64'(a.lat), 64'(e.lat));
    check($sformatf("v%0d.pc_source", idx), 64'(a.pc_src), 64'(e.pc_src));
    check($sformatf("v%0d.reg_write_cycles", idx), 64'(a.reg_wr), 64'(e.reg_wr));
    check($sformatf("v%0d.mem_to_reg", idx), 64'(a.m2r), 64'(e.m2r));
    check($sformatf("v%0d.mem_write_cycles", idx), 64'(a.mem_wr), 64'(e.mem_wr));
    check($sformatf("v%0d.illegal_pulses", idx), 64'(a.illegal), 64'(e.illegal));
    check($sformatf("v%0d.mem_req_cycles", idx), 64'(a.mreq), 64'(e.mreq));
    check($sformatf("v%0d.data_req_cycles", idx), 64'(a.dreq), 64'(e.dreq));
    check($sformatf("v%0d.ir_write_cycles", idx), 64'(a.ir_wr), 64'd1);
  endtask

  // Run one instruction from IF until it retires; entered and left just after a posedge
  task automatic run_instr(input int idx, input vec_t v);
    res_t a;
    int   cyc;
    int   acc;
    bit   done;
    exp_q.push_back(v);
    bus.opcode = v.opcode;
    bus.bcond  = v.bcond;
    a.lat = 0; a.pc_src = 2'd0; a.reg_wr = 0; a.m2r = 2'd0; a.mem_wr = 0;
    a.illegal = 0; a.mreq = 0; a.dreq = 0; a.ir_wr = 0;
    cyc = 0; acc = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      // Memory model: complete after the configured number of wait cycles
      if (bus.mem_req) begin
        bus.mem_ready = (acc >= (bus.i_or_d ? v.mem_wait : v.if_wait));
        acc = bus.mem_ready ? 0 : acc + 1;
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cyc++;
      if (bus.mem_req) a.mreq++;
      if (bus.mem_req && bus.i_or_d) a.dreq++;
      if (bus.mem_write) a.mem_wr++;
      if (bus.ir_write) a.ir_wr++;
      if (illegal_inst) a.illegal++;
      if (bus.reg_write) begin
        a.reg_wr++;
        a.m2r = bus.mem_to_reg;
      end
      if (bus.pc_write) begin
        a.pc_src = bus.pc_source;
        a.lat    = cyc;
        done     = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    exp_instret++;
    compare(idx, a);
    check($sformatf("v%0d.state_after", idx), 64'(state), 64'd0);
    check($sformatf("v%0d.instret", idx), 64'(instret), 64'(exp_instret));
  endtask

  int exp_st[4];
  int exp_rw[4];
  vec_t ecall_v;

  initial begin
    //            opcode   bc    ifw mw  lat pc    rw m2r   mw ill mrq drq
    vecs[0]  = '{7'h13, 1'b0, 0, 0, 4, 2'd0, 1, 2'd0, 0, 0, 1, 0};  // ADDI
    vecs[1]  = '{7'h33, 1'b0, 1, 0, 5, 2'd0, 1, 2'd0, 0, 0, 2, 0};  // ADD, 1 fetch wait
    vecs[2]  = '{7'h03, 1'b0, 0, 2, 7, 2'd0, 1, 2'd1, 0, 0, 4, 3};  // LW, 2 mem waits
    vecs[3]  = '{7'h23, 1'b0, 1, 1, 6, 2'd0, 0, 2'd0, 2, 0, 4, 2};  // SW, waits both
    vecs[4]  = '{7'h63, 1'b1, 0, 0, 3, 2'd1, 0, 2'd0, 0, 0, 1, 0};  // BEQ taken
    vecs[5]  = '{7'h63, 1'b0, 0, 0, 3, 2'd0, 0, 2'd0, 0, 0, 1, 0};  // BEQ not taken
    vecs[6]  = '{7'h6F, 1'b0, 0, 0, 4, 2'd1, 1, 2'd2, 0, 0, 1, 0};  // JAL
    vecs[7]  = '{7'h67, 1'b0, 2, 0, 6, 2'd2, 1, 2'd2, 0, 0, 3, 0};  // JALR, 2 fetch waits
    vecs[8]  = '{7'h7F, 1'b0, 0, 0, 2, 2'd0, 0, 2'd0, 0, 1, 1, 0};  // illegal
    vecs[9]  = '{7'h03, 1'b0, 0, 0, 5, 2'd0, 1, 2'd1, 0, 0, 2, 1};  // LW zero-wait
    vecs[10] = '{7'h23, 1'b1, 0, 0, 4, 2'd0, 0, 2'd0, 1, 0, 2, 1};  // SW zero-wait
    vecs[11] = '{7'h00, 1'b0, 0, 0, 2, 2'd0, 0, 2'd0, 0, 1, 1, 0};  // illegal 0
    vecs[12] = '{7'h13, 1'b1, 0, 0, 4, 2'd0, 1, 2'd0, 0, 0, 1, 0};  // ADDI, bcond ignored

    reset          = 1'b0;
    bus.opcode     = 7'h13;
    bus.bcond      = 1'b0;
    bus.mem_ready  = 1'b1;
    bus4.opcode    = 7'h13;
    bus4.bcond     = 1'b0;
    bus4.mem_ready = 1'b1;

    // Reset held: everything quiet, including the IF memory request
    repeat (2) @(negedge clk);
    check("rst.mem_req", 64'(bus.mem_req), 64'd0);
    check("rst.ir_write", 64'(bus.ir_write), 64'd0);
    check("rst.pc_write", 64'(bus.pc_write), 64'd0);
    check("rst.state", 64'(state), 64'd0);
    check("rst.instret", 64'(instret), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // ADDI cycle-by-cycle: IF, ID, EX, WB with reg_write only in WB
    exp_st = '{0, 1, 2, 4};
    exp_rw = '{0, 0, 0, 1};
    bus.opcode = 7'h13;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = 1'b1;
      @(negedge clk);
      check($sformatf("addi.state%0d", i), 64'(state), 64'(exp_st[i]));
      check($sformatf("addi.reg_write%0d", i), 64'(bus.reg_write), 64'(exp_rw[i]));
      @(posedge clk);
      #1;
    end
    exp_instret = 1;
    check("addi.instret", 64'(instret), 64'd1);
    check("addi.state_after", 64'(state), 64'd0);

    for (int i = 0; i < NVEC; i++) begin
      run_instr(i, vecs[i]);
    end

`ifdef ECALL_HALT_EN
    // ECALL parks the core; no further requests or PC updates
    bus.opcode    = 7'h73;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check("ecall.if_state", 64'(state), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("ecall.id_state", 64'(state), 64'd1);
    check("ecall.id_pc_write", 64'(bus.pc_write), 64'd0);
    exp_instret++;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check($sformatf("halt.state%0d", i), 64'(state), 64'd5);
      check($sformatf("halt.is_halted%0d", i), 64'(is_halted), 64'd1);
      check($sformatf("halt.mem_req%0d", i), 64'(bus.mem_req), 64'd0);
      check($sformatf("halt.pc_write%0d", i), 64'(bus.pc_write), 64'd0);
    end
    check("halt.instret", 64'(instret), 64'(exp_instret));
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    exp_instret = 0;
    check("halt.reset_state", 64'(state), 64'd0);
`else
    // ECALL retires as a NOP: IF, ID, back to IF
    ecall_v = '{7'h73, 1'b0, 0, 0, 2, 2'd0, 0, 2'd0, 0, 0, 1, 0};
    run_instr(NVEC, ecall_v);
    check("ecall.is_halted", 64'(is_halted), 64'd0);
`endif

    // Reset asserted mid-MEM of a store: request drops immediately
    bus.opcode = 7'h23;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1 bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 bus.mem_ready = 1'b0;
    @(negedge clk);
    check("swrst.pre_state", 64'(state), 64'd3);
    check("swrst.pre_mem_req", 64'(bus.mem_req), 64'd1);
    check("swrst.pre_mem_write", 64'(bus.mem_write), 64'd1);
    #2 reset = 1'b0;
    #1;
    exp_instret = 0;
    check("swrst.mem_req", 64'(bus.mem_req), 64'd0);
    check("swrst.mem_write", 64'(bus.mem_write), 64'd0);
    check("swrst.state", 64'(state), 64'd0);
    check("swrst.instret", 64'(instret), 64'(exp_instret));
    @(posedge clk);
    #1;
    check("swrst.held_mem_req", 64'(bus.mem_req), 64'd0);
    reset = 1'b1;

    // 4-bit counter instance: one ADDI retires every 4 cycles
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("wrap.instret15", 64'(instret4), 64'd15);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("wrap.instret0", 64'(instret4), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
